// File: rtl/dice_roll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dice_roll_ctrl
// Purpose  : Roll-button front end: synchronizer, debouncer, and a coast FSM
//            that emits a decelerating roll_en pulse train after release.
// Revision : 1.0 - initial release
// ============================================================================
module dice_roll_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BASE_GAP        = 64,
    parameter int PULSE_CYCLES    = 8,
    parameter int SLOW_STEPS      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic roll_en,
    output logic rolling,
    output logic settled
);

    localparam int c_CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_STEP_W    = (SLOW_STEPS > 1) ? $clog2(SLOW_STEPS) : 1;
    localparam int c_GAP_MAX   = BASE_GAP * SLOW_STEPS;
    localparam int c_TMR_MAX   = (c_GAP_MAX > PULSE_CYCLES) ? c_GAP_MAX : PULSE_CYCLES;
    localparam int c_TMR_W     = $clog2(c_TMR_MAX + 1);

    localparam logic [c_CNT_W-1:0]  c_CNT_LAST   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_STEP_W-1:0] c_STEP_LAST  = c_STEP_W'(SLOW_STEPS - 1);
    localparam logic [c_TMR_W-1:0]  c_GAP_FIRST  = c_TMR_W'(BASE_GAP - 1);
    localparam logic [c_TMR_W-1:0]  c_PULSE_LOAD = c_TMR_W'(PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ROLL   = 3'd1,
        S_GAP    = 3'd2,
        S_PULSE  = 3'd3,
        S_SETTLE = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_btn_s;
    logic                   r_db;
    logic [c_CNT_W-1:0]     r_cnt;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_STEP_W-1:0]    r_step;
    logic [c_STEP_W-1:0]    w_step_nxt;
    logic [c_TMR_W-1:0]     r_tmr;
    logic [c_TMR_W-1:0]     w_tmr_nxt;
    logic [c_TMR_W-1:0]     w_gap_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn};
        end
    end

    assign w_btn_s = r_sync[SYNC_STAGES-1];

    // Any return to the accepted level restarts the stability count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else if (w_btn_s == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_db  <= w_btn_s;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Next gap length is BASE_GAP*(step+2); product formed at 32 bits first.
    assign w_gap_load = c_TMR_W'(BASE_GAP * (int'(r_step) + 2) - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_tmr_nxt   = r_tmr;
        case (r_state)
            S_IDLE: begin
                if (r_db) w_state_nxt = S_ROLL;
            end
            S_ROLL: begin
                if (!r_db) begin
                    w_state_nxt = S_GAP;
                    w_step_nxt  = '0;
                    w_tmr_nxt   = c_GAP_FIRST;
                end
            end
            S_GAP: begin
                if (r_db) begin
                    w_state_nxt = S_ROLL;
                end else if (r_tmr == '0) begin
                    w_state_nxt = S_PULSE;
                    w_tmr_nxt   = c_PULSE_LOAD;
                end else begin
                    w_tmr_nxt   = r_tmr - c_TMR_W'(1);
                end
            end
            S_PULSE: begin
                if (r_db) begin
                    w_state_nxt = S_ROLL;
                end else if (r_tmr == '0) begin
                    if (r_step == c_STEP_LAST) begin
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_state_nxt = S_GAP;
                        w_step_nxt  = r_step + c_STEP_W'(1);
                        w_tmr_nxt   = w_gap_load;
                    end
                end else begin
                    w_tmr_nxt   = r_tmr - c_TMR_W'(1);
                end
            end
            S_SETTLE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decode the state register only, so btn never reaches them combinationally.
    always_comb begin
        roll_en = 1'b0;
        rolling = 1'b0;
        settled = 1'b0;
        case (r_state)
            S_ROLL:   begin roll_en = 1'b1; rolling = 1'b1; end
            S_GAP:    begin rolling = 1'b1; end
            S_PULSE:  begin roll_en = 1'b1; rolling = 1'b1; end
            S_SETTLE: begin settled = 1'b1; end
            default:  begin roll_en = 1'b0; end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dice_roll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dice_roll_ctrl
// Purpose  : Scoreboard bench: stimulus queues expected {roll_en,rolling,settled}
//            per cycle; a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dice_roll_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic btn_a;
    logic btn_b;
    logic roll_en_a, rolling_a, settled_a;
    logic roll_en_b, rolling_b, settled_b;

    always #5 clk = ~clk;

    dice_roll_ctrl #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .BASE_GAP(2),
        .PULSE_CYCLES(8), .SLOW_STEPS(3)
    ) u_dut_a (
        .clk(clk), .rst(rst), .btn(btn_a),
        .roll_en(roll_en_a), .rolling(rolling_a), .settled(settled_a)
    );

    dice_roll_ctrl #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .BASE_GAP(1),
        .PULSE_CYCLES(8), .SLOW_STEPS(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .btn(btn_b),
        .roll_en(roll_en_b), .rolling(rolling_b), .settled(settled_b)
    );

    typedef struct {
        int         cyc;
        logic [2:0] val;
        int         dut;
        int         test;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cur_test = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every queued expectation on its cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t       e;
            logic [2:0] act;
            e   = q.pop_front();
            act = (e.dut == 0) ? {roll_en_a, rolling_a, settled_a}
                               : {roll_en_b, rolling_b, settled_b};
            n_checks++;
            if (e.cyc != cyc) begin
                n_errors++;
                $display("FAIL missed_t%0d cyc=%0d expected at cyc=%0d", e.test, cyc, e.cyc);
            end else if (act !== e.val) begin
                n_errors++;
                $display("FAIL outputs_t%0d dut=%0d cyc=%0d got {roll_en,rolling,settled}=%b required=%b",
                         e.test, e.dut, cyc, act, e.val);
            end
        end
    end

    task automatic exp_run(input int from, input int n, input logic [2:0] v, input int dut);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.cyc  = from + i;
            e.val  = v;
            e.dut  = dut;
            e.test = cur_test;
            q.push_back(e);
        end
    endtask

    // Hand-derived coast for BASE_GAP=2, PULSE_CYCLES=8, SLOW_STEPS=3, first GAP at g.
    task automatic push_coast(input int g);
        exp_run(g,      2, 3'b010, 0);
        exp_run(g + 2,  8, 3'b110, 0);
        exp_run(g + 10, 4, 3'b010, 0);
        exp_run(g + 14, 8, 3'b110, 0);
        exp_run(g + 22, 6, 3'b010, 0);
        exp_run(g + 28, 8, 3'b110, 0);
        exp_run(g + 36, 1, 3'b001, 0);
        exp_run(g + 37, 5, 3'b000, 0);
    endtask

    task automatic step_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: reset with button held, then release and full coast.
        cur_test = 1;
        rst   = 1'b1;
        btn_a = 1'b1;
        btn_b = 1'b0;
        exp_run(1, 3, 3'b000, 0);
        step_cyc(3);
        rst = 1'b0;
        exp_run(4, 6, 3'b000, 0);
        exp_run(10, 1, 3'b110, 0);
        step_cyc(9);
        btn_a = 1'b0;
        exp_run(13, 6, 3'b110, 0);
        push_coast(19);
        step_cyc(48);

        // Test 2: clean press held 20 cycles, release, full coast.
        cur_test = 2;
        btn_a = 1'b1;
        exp_run(61, 6, 3'b000, 0);
        exp_run(67, 20, 3'b110, 0);
        step_cyc(20);
        btn_a = 1'b0;
        push_coast(87);
        step_cyc(48);

        // Test 3: bounce every 3 cycles never reaches the debounced level.
        cur_test = 3;
        exp_run(129, 40, 3'b000, 0);
        for (int i = 0; i < 10; i++) begin
            btn_a = (i % 2 == 0);
            step_cyc(3);
        end
        btn_a = 1'b0;
        step_cyc(10);

        // Test 4: re-press in second GAP, then re-press landing in third GAP.
        cur_test = 4;
        btn_a = 1'b1;
        exp_run(169, 6, 3'b000, 0);
        exp_run(175, 10, 3'b110, 0);
        step_cyc(10);
        btn_a = 1'b0;
        exp_run(185, 2, 3'b010, 0);
        exp_run(187, 8, 3'b110, 0);
        exp_run(195, 4, 3'b010, 0);
        exp_run(199, 3, 3'b110, 0);
        step_cyc(17);
        btn_a = 1'b1;
        exp_run(202, 15, 3'b110, 0);
        step_cyc(15);
        btn_a = 1'b0;
        exp_run(217, 2, 3'b010, 0);
        exp_run(219, 8, 3'b110, 0);
        exp_run(227, 4, 3'b010, 0);
        exp_run(231, 8, 3'b110, 0);
        exp_run(239, 2, 3'b010, 0);
        step_cyc(24);
        btn_a = 1'b1;
        exp_run(241, 16, 3'b110, 0);
        step_cyc(16);
        btn_a = 1'b0;
        push_coast(257);
        step_cyc(48);

        // Test 5: reset during second PULSE.
        cur_test = 5;
        btn_a = 1'b1;
        exp_run(299, 6, 3'b000, 0);
        exp_run(305, 12, 3'b110, 0);
        step_cyc(12);
        btn_a = 1'b0;
        exp_run(317, 2, 3'b010, 0);
        exp_run(319, 8, 3'b110, 0);
        exp_run(327, 4, 3'b010, 0);
        exp_run(331, 2, 3'b110, 0);
        exp_run(333, 15, 3'b000, 0);
        step_cyc(22);
        rst = 1'b1;
        step_cyc(1);
        rst = 1'b0;
        step_cyc(14);

        // Test 6: minimum gap, single step (second instance).
        cur_test = 6;
        btn_b = 1'b1;
        exp_run(348, 6, 3'b000, 1);
        exp_run(354, 13, 3'b110, 1);
        step_cyc(13);
        btn_b = 1'b0;
        exp_run(367, 1, 3'b010, 1);
        exp_run(368, 8, 3'b110, 1);
        exp_run(376, 1, 3'b001, 1);
        exp_run(377, 5, 3'b000, 1);
        step_cyc(21);

        step_cyc(2);
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL leftover_expectations got=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dice_roll_ctrl.md
# dice_roll_ctrl

Roll-button front end for the dice display path. Takes the raw, asynchronous roll pushbutton, synchronizes and debounces it, and drives the roll-enable level consumed by the die counter/segment stage. After release, it emits a decelerating train of roll-enable pulses so the die visibly "slows down" before settling. It then flags the settled result with a one-cycle strobe.

## Interface
- SYNC_STAGES, 2: flip-flops in the input synchronizer (≥2).
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a new button level (≥1).
- BASE_GAP, 64: gap unit in cycles; coast step k waits BASE_GAP*(k+1) cycles (≥1).
- PULSE_CYCLES, 8: width of each coast roll_en pulse. It must be ≥ the downstream clock-divide ratio so the slower die clock samples it.
- SLOW_STEPS, 6: number of coast pulses after release (≥1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- btn  in  1  raw roll pushbutton, asynchronous, active-high, bouncy.
- roll_en  out  1  roll enable to die stage; high = advance die.
- rolling  out  1  high while a roll or coast is in progress.
- settled  out  1  one-cycle strobe when coasting has finished.

## Operation
- Synchronizer: btn passes through SYNC_STAGES flops, giving btn_s.
- Debouncer: register db and counter cnt, with cnt width clog2(DEBOUNCE_CYCLES).
  - If btn_s == db: cnt <= 0.
  - Otherwise, cnt increments. When cnt == DEBOUNCE_CYCLES-1, db <= btn_s and cnt <= 0.
  - Any bounce back to db's level before then clears cnt.
- FSM states: IDLE, ROLL, GAP, PULSE, SETTLE. Registers: step (0..SLOW_STEPS-1) and tmr (width clog2(max(BASE_GAP*SLOW_STEPS, PULSE_CYCLES)+1)).
- IDLE:
  - Outputs: roll_en=0, rolling=0.
  - db==1 → ROLL.
- ROLL:
  - Outputs: roll_en=1, rolling=1.
  - db==0 → GAP with step<=0 and tmr<=BASE_GAP-1.
- GAP:
  - Outputs: roll_en=0, rolling=1.
  - tmr decrements each cycle. At tmr==0 → PULSE with tmr<=PULSE_CYCLES-1.
- PULSE:
  - Outputs: roll_en=1, rolling=1.
  - tmr decrements. At tmr==0:
    - If step==SLOW_STEPS-1 → SETTLE.
    - Otherwise, step<=step+1, tmr<=BASE_GAP*(step+2)-1, → GAP.
- SETTLE:
  - Outputs: settled=1, roll_en=0, rolling=0.
  - → IDLE unconditionally.
- Re-press: db==1 in GAP or PULSE → ROLL next cycle. The current step is abandoned, and step/tmr are reloaded on the next release.
- db==1 in SETTLE: settled still pulses. The FSM goes to IDLE, then to ROLL on the following cycle.
- Arithmetic: gap products are computed at full width with no truncation. The parameter ranges above guarantee tmr fits.

## Timing
- Reset, on the first posedge with rst=1:
  - synchronizer flops=0, db=0, cnt=0, state=IDLE, step=0, tmr=0.
  - roll_en=0, rolling=0, settled=0.
- All outputs are registered and decoded from the state register; no combinational path from btn.
- Button held through reset release is treated as a fresh press and debounced normally.
- Press latency:
  - A clean btn rise at edge 0 gives btn_s=1 after SYNC_STAGES edges.
  - db=1 follows DEBOUNCE_CYCLES edges later.
  - roll_en=1 follows one edge after that.
  - Total: SYNC_STAGES+DEBOUNCE_CYCLES+1.
- Release latency is identical; the first GAP cycle (roll_en=0) appears at the same offset.
- Coast duration, from first GAP cycle to the SETTLE cycle: BASE_GAP*S*(S+1)/2 + S*PULSE_CYCLES cycles, where S=SLOW_STEPS. The settled strobe occupies the next cycle.
- Bounce shorter than DEBOUNCE_CYCLES never changes db and never affects the FSM.
- rst asserted mid-coast returns to IDLE with all outputs 0 on that edge; no settled strobe.

## Test plan
Overrides for all tests: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, BASE_GAP=2, PULSE_CYCLES=8, SLOW_STEPS=3.
- Reset: hold rst 3 cycles with btn=1 → roll_en, rolling, settled all 0 during reset. roll_en rises exactly 7 cycles after rst deasserts.
- Clean press/release: btn high 20 cycles, then low → roll_en rises 7 cycles after press.
  - After release, the roll_en pattern is 0×2, 1×8, 0×4, 1×8, 0×6, 1×8.
  - Then settled=1 for exactly 1 cycle, with rolling=0 from that cycle on.
- Bounce rejection: while IDLE, btn toggles every 3 cycles for 30 cycles, then settles low → db never rises, roll_en stays 0 throughout.
- Re-press during coast: release, then press again at the second GAP → roll_en=1 continuously, 7 cycles after the re-press. No settled strobe until the next full release and coast completes.
- Reset mid-coast: rst asserted during the second PULSE → next cycle roll_en=0, rolling=0, settled=0, and state is IDLE.
- Min-gap boundary: BASE_GAP=1, SLOW_STEPS=1 → after release: 1 cycle roll_en=0, then 8 cycles roll_en=1, then settled for 1 cycle.
